uart_tx_cfg: RTL and testbench



---
 rtl/uart_tx_cfg.sv | 151 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (5..DATA_MAX data bits, 1/2 stop, optional parity)
// Optional parity support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
  parameter int DATA_MAX   = 8,
  parameter int OVERSAMPLE = 16,
  parameter int BCNT_W     = $clog2(DATA_MAX + 1),
  parameter int SCNT_W     = $clog2(OVERSAMPLE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                tx_start,
  input  logic [DATA_MAX-1:0] data_in,
  input  logic [BCNT_W-1:0]   cfg_data_bits,
  input  logic                cfg_stop2,
  input  logic [1:0]          cfg_parity,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done_tick
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state;
  logic [SCNT_W-1:0]   s_cnt;
  logic [BCNT_W-1:0]   b_cnt;
  logic [BCNT_W-1:0]   n_lat;
  logic [DATA_MAX-1:0] sh;
  logic                stop2_lat;
  logic [BCNT_W-1:0]   n_clamp;
  logic                bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en;
  logic par_odd;
  logic par_acc;
`else
  logic unused_parity;
  assign unused_parity = ^cfg_parity;
`endif

  always_comb begin
    n_clamp = cfg_data_bits;
    if (cfg_data_bits < BCNT_W'(5))
      n_clamp = BCNT_W'(5);
    else if (cfg_data_bits > BCNT_W'(DATA_MAX))
      n_clamp = BCNT_W'(DATA_MAX);
  end

  assign bit_end = s_tick && (s_cnt == SCNT_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      b_cnt        <= '0;
      n_lat        <= '0;
      sh           <= '0;
      stop2_lat    <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      par_acc      <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      if (state == IDLE) begin
        // Acceptance is not gated by s_tick so the FIFO sees minimum latency.
        if (tx_start) begin
          sh        <= data_in;
          n_lat     <= n_clamp;
          stop2_lat <= cfg_stop2;
          s_cnt     <= '0;
          b_cnt     <= '0;
          tx        <= 1'b0;
          tx_busy   <= 1'b1;
          state     <= START;
`ifdef UART_TX_PARITY_EN
          par_en    <= ^cfg_parity;
          par_odd   <= cfg_parity[1];
          par_acc   <= 1'b0;
`endif
        end
      end else if (s_tick) begin
        if (bit_end)
          s_cnt <= '0;
        else
          s_cnt <= s_cnt + 1'b1;

        if (bit_end) begin
          case (state)
            START: begin
              tx    <= sh[0];
              state <= DATA;
            end
            DATA: begin
              sh <= sh >> 1;
`ifdef UART_TX_PARITY_EN
              par_acc <= par_acc ^ sh[0];
`endif
              if (b_cnt == n_lat - BCNT_W'(1)) begin
                b_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                if (par_en) begin
                  tx    <= par_acc ^ sh[0] ^ par_odd;
                  state <= PARITY;
                end else begin
                  tx    <= 1'b1;
                  state <= STOP;
                end
`else
                tx    <= 1'b1;
                state <= STOP;
`endif
              end else begin
                b_cnt <= b_cnt + 1'b1;
                tx    <= sh[1];
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              tx    <= 1'b1;
              state <= STOP;
            end
`endif
            STOP: begin
              if (b_cnt == BCNT_W'(stop2_lat)) begin
                b_cnt        <= '0;
                tx           <= 1'b1;
                tx_busy      <= 1'b0;
                tx_done_tick <= 1'b1;
                state        <= IDLE;
              end else begin
                b_cnt <= b_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed, table-driven bench for uart_tx_cfg (default parameters)
// Expectations for parity rows follow UART_TX_PARITY_EN.
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = '0;
  logic [3:0] cfg_data_bits = 4'd8;
  logic       cfg_stop2 = 1'b0;
  logic [1:0] cfg_parity = 2'b00;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 1;
  int tick_ph  = 0;

  uart_tx_cfg #(.DATA_MAX(8), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_tick        (s_tick),
    .tx_start      (tx_start),
    .data_in       (data_in),
    .cfg_data_bits (cfg_data_bits),
    .cfg_stop2     (cfg_stop2),
    .cfg_parity    (cfg_parity),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done_tick  (tx_done_tick)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
      s_tick  = (tick_ph == 0);
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  nbits;
    logic        stop2;
    logic [1:0]  par;
    int          len;
    logic [15:0] pat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the acceptance edge; returns at the negedge after done.
  task automatic check_frame(input string name, input int len, input logic [15:0] pat);
    int  early_done;
    logic [15:0] p;
    p = pat;
    early_done = 0;
    chk({name, " busy"}, tx_busy, 1'b1);
    for (int c = 0; c < len * OS; c++) begin
      if (c > 0) @(negedge clk);
      if (tx_done_tick) early_done++;
      if ((c % OS) == 0 || (c % OS) == OS - 1)
        chk($sformatf("%s bit%0d c%0d", name, c / OS, c % OS), tx, p[c / OS]);
    end
    chk({name, " early_done"}, early_done, 0);
    @(negedge clk);
    chk({name, " done"}, tx_done_tick, 1'b1);
    chk({name, " idle_busy"}, tx_busy, 1'b0);
    chk({name, " stop_tx"}, tx, 1'b1);
  endtask

  task automatic start_frame(input vec_t v);
    data_in       = v.data;
    cfg_data_bits = v.nbits;
    cfg_stop2     = v.stop2;
    cfg_parity    = v.par;
    tx_start      = 1'b1;
    @(negedge clk);
    tx_start      = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   dones;

    vecs[0] = '{8'hA5, 4'd8,  1'b0, 2'b00, 10, 16'h034A};
    vecs[1] = '{8'hF3, 4'd5,  1'b1, 2'b00, 8,  16'h00E6};
    vecs[2] = '{8'hF3, 4'd2,  1'b1, 2'b00, 8,  16'h00E6};
    vecs[3] = '{8'h3C, 4'd12, 1'b0, 2'b11, 10, 16'h0278};
    vecs[4] = '{8'h2A, 4'd6,  1'b0, 2'b00, 8,  16'h00D4};
`ifdef UART_TX_PARITY_EN
    vecs[5] = '{8'h07, 4'd7,  1'b0, 2'b01, 10, 16'h030E};
    vecs[6] = '{8'h07, 4'd7,  1'b0, 2'b10, 10, 16'h020E};
`else
    vecs[5] = '{8'h07, 4'd7,  1'b0, 2'b01, 9,  16'h010E};
    vecs[6] = '{8'h07, 4'd7,  1'b0, 2'b10, 9,  16'h010E};
`endif

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1'b1);
    chk("reset busy", tx_busy, 1'b0);
    chk("reset done", tx_done_tick, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_frame(vecs[i]);
      check_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].pat);
      @(negedge clk);
      chk($sformatf("vec%0d done_1clk", i), tx_done_tick, 1'b0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back with tx_start held and config changed mid-frame.
    data_in = 8'hA5; cfg_data_bits = 4'd8; cfg_stop2 = 1'b0; cfg_parity = 2'b00;
    tx_start = 1'b1;
    @(negedge clk);
    data_in = 8'h3C; cfg_data_bits = 4'd5; cfg_stop2 = 1'b1;
    check_frame("b2b first", 10, 16'h034A);
    chk("b2b gap tx", tx, 1'b1);
    @(negedge clk);
    tx_start = 1'b0;
    chk("b2b restart tx", tx, 1'b0);
    chk("b2b restart done", tx_done_tick, 1'b0);
    check_frame("b2b second", 8, 16'h00F8);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_done_tick) dones++;
    end
    chk("b2b no third", dones + {31'd0, tx_busy}, 0);

    // Reset during the 4th data bit with s_tick every 3rd clk.
    tick_div = 3;
    start_frame(vecs[0]);
    repeat (3 * (4 * OS + 8)) @(negedge clk);
    chk("mid busy", tx_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset tx", tx, 1'b1);
    chk("mid reset busy", tx_busy, 1'b0);
    chk("mid reset done", tx_done_tick, 1'b0);
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_done_tick || !tx) dones++;
    end
    chk("mid reset quiet", dones, 0);
    tick_div = 1;
    repeat (3) @(negedge clk);
    start_frame(vecs[1]);
    check_frame("post reset", vecs[1].len, vecs[1].pat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
